// File: rtl/traffic_pkg.sv
// Shared definitions for the trafficlight subsystem: clock rate, sensor FSM
// states and the 6-bit light encoding used by the controller.
package traffic_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        STUCK   = 2'd2
    } sensor_state_t;

    // Light encoding is {main R, main Y, main G, side R, side Y, side G}.
    localparam logic [5:0] LIGHTS_MAIN_GREEN  = 6'b001_100;
    localparam logic [5:0] LIGHTS_MAIN_YELLOW = 6'b010_100;
    localparam logic [5:0] LIGHTS_SIDE_GREEN  = 6'b100_001;
    localparam logic [5:0] LIGHTS_SIDE_YELLOW = 6'b100_010;
    localparam logic [5:0] LIGHTS_ALL_RED     = 6'b100_100;

endpackage

// File: rtl/car_sensor_conditioner_debounce_filter.sv
// Two-flop synchroniser followed by a level debouncer: a new level is accepted
// only after it has held for DEBOUNCE_CYCLES consecutive synchronised samples.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    output logic sensor_db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= sensor_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the count.
            if (r_sync2 != r_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign sensor_db = r_db;

endmodule

// File: rtl/car_sensor_conditioner.sv
// Turns the raw vehicle-loop signal into a latched car request for the
// trafficlight controller, with stuck-sensor detection and an arrival count.
module car_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [31:0] STUCK_CYCLES    = 32'd3_000_000_000,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_raw,
    input  logic               served,
    output logic               car,
    output logic               stuck_fault,
    output logic [COUNT_W-1:0] car_count
);

    localparam int unsigned STUCK_W = $clog2({1'b0, STUCK_CYCLES} + 33'd1);
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_CYCLES[STUCK_W-1:0];

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic               w_sensor_db;
    logic               w_arrival;
    logic               w_stuck_hit;
    logic               r_db_d;
    logic [STUCK_W-1:0] r_stuck_cnt;
    logic [COUNT_W-1:0] r_count;
    logic               r_car;
    logic               r_fault;
    sensor_state_t      r_state;
    sensor_state_t      w_state_next;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .sensor_db  (w_sensor_db)
    );

    // Arrival is the rising edge of the debounced level against its registered copy.
    assign w_arrival   = w_sensor_db & ~r_db_d;
    assign w_stuck_hit = w_sensor_db && (r_stuck_cnt == STUCK_MAX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_stuck_hit)    w_state_next = STUCK;
                else if (w_arrival) w_state_next = PENDING;
            end
            PENDING: begin
                if (w_stuck_hit)                w_state_next = STUCK;
                else if (served && !w_arrival)  w_state_next = IDLE;
            end
            STUCK: begin
                if (!w_sensor_db) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_d      <= 1'b0;
            r_stuck_cnt <= '0;
            r_count     <= '0;
            r_state     <= IDLE;
            r_car       <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_db_d  <= w_sensor_db;
            r_state <= w_state_next;
            r_car   <= (w_state_next == PENDING) || (w_state_next == STUCK);
            r_fault <= (w_state_next == STUCK);
            if (w_arrival) begin
                r_count <= sat_inc(r_count);
            end
            if (!w_sensor_db) begin
                r_stuck_cnt <= '0;
            end else if (r_stuck_cnt != STUCK_MAX) begin
                r_stuck_cnt <= r_stuck_cnt + 1'b1;
            end
        end
    end

    assign car         = r_car;
    assign stuck_fault = r_fault;
    assign car_count   = r_count;

endmodule
